// File: rtl/rv32im_pkg.sv
// Shared RV32IM definitions: ALU opcodes, M-extension funct3 and MDU FSM states.
// Imported by the execute-stage units.
package rv32im_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } mdu_funct3_e;

  typedef enum logic [2:0] {
    IDLE, MUL, DIV, FIX, DONE
  } mdu_state_e;

endpackage

// File: rtl/rv32im_div_step.sv
// Restoring divider iteration: resolves DIV_BITS quotient bits per call
// on unsigned magnitudes.
module rv32im_div_step
  import rv32im_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DIV_BITS = 1
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0]   r;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] q;

  always_comb begin
    r = {1'b0, rem};
    q = quo;
    t = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      r = {r[WIDTH-1:0], q[WIDTH-1]};
      q = {q[WIDTH-2:0], 1'b0};
      t = r - {1'b0, dvs};
      // top bit of the trial is the borrow
      if (!t[WIDTH]) begin
        r    = t;
        q[0] = 1'b1;
      end
    end
    rem_nxt = r[WIDTH-1:0];
    quo_nxt = q;
  end

endmodule

// File: rtl/rv32im_mdu.sv
// RV32IM multiply/divide unit: single-cycle registered multiply,
// iterative restoring divide with a sign-fix state.
module rv32im_mdu
  import rv32im_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DIV_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy
);

  localparam int STEPS = WIDTH / DIV_BITS;
  localparam int CW    = $clog2(STEPS) + 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e state, state_d;

  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q, res_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;

  logic               accept;
  logic               in_sgn;
  logic               in_special;
  logic [WIDTH-1:0]   in_ua, in_ub;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;
  logic [2*WIDTH-1:0] ext_a, ext_b;
  logic               sgn, dbz, ovf;
  logic               neg_q, neg_r;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign accept = (state == IDLE) && i_valid && !i_flush;
  assign in_sgn = ~i_funct3[0];
  assign in_ua  = (in_sgn && i_rs1_data[WIDTH-1]) ?
                  -i_rs1_data : i_rs1_data;
  assign in_ub  = (in_sgn && i_rs2_data[WIDTH-1]) ?
                  -i_rs2_data : i_rs2_data;
  assign in_special = (i_rs2_data == '0) ||
                      (in_sgn && i_rs1_data == MIN &&
                       i_rs2_data == '1);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (i_valid) begin
          if (!i_funct3[2])   state_d = MUL;
          else if (in_special) state_d = FIX;
          else                state_d = DIV;
        end
      end
      MUL:  state_d = DONE;
      DIV:  if (cnt_q == LAST) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  rv32im_div_step #(
    .WIDTH    (WIDTH),
    .DIV_BITS (DIV_BITS)
  ) u_div_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvs     (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // MUL low half is sign-agnostic, so only the high forms pick extension
  always_comb begin
    ext_a = {{WIDTH{(op_q != F3_MULHU) && a_q[WIDTH-1]}}, a_q};
    ext_b = {{WIDTH{(op_q == F3_MUL || op_q == F3_MULH) &&
                    b_q[WIDTH-1]}}, b_q};
  end

  assign sgn   = ~op_q[0];
  assign dbz   = (b_q == '0);
  assign ovf   = sgn && (a_q == MIN) && (b_q == '1);
  assign neg_q = sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign neg_r = sgn && a_q[WIDTH-1];

  always_comb begin
    q_fix = neg_q ? -quo_q : quo_q;
    r_fix = neg_r ? -rem_q : rem_q;
    if (dbz) begin
      q_fix = '1;
      r_fix = a_q;
    end else if (ovf) begin
      q_fix = a_q;
      r_fix = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      res_q  <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        op_q  <= i_funct3;
        a_q   <= i_rs1_data;
        b_q   <= i_rs2_data;
        rem_q <= '0;
        quo_q <= in_ua;
        dvs_q <= in_ub;
        cnt_q <= '0;
      end
      if (state == MUL) prod_q <= ext_a * ext_b;
      if (state == DIV) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q + CW'(1);
      end
      if (state == FIX) res_q <= op_q[1] ? r_fix : q_fix;
    end
  end

  assign o_result = !op_q[2] ?
                    ((op_q == F3_MUL) ? prod_q[WIDTH-1:0] :
                                        prod_q[2*WIDTH-1:WIDTH]) :
                    res_q;
  assign o_ready  = (state == IDLE);
  assign o_valid  = (state == DONE);
  assign o_busy   = (state != IDLE);

endmodule

// File: tb/tb_rv32im_mdu.sv
// Directed bench for rv32im_mdu: arithmetic vectors, latency,
// backpressure, flush and reset abort.
module tb_rv32im_mdu;

  localparam int DB   = 1;
  localparam int DLAT = 32 / DB + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  rv32im_mdu #(
    .WIDTH    (32),
    .DIV_BITS (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_funct3   (i_funct3),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // latency counts the acceptance edge as 1
  task automatic wait_valid(output int lat);
    lat = 1;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (o_valid) break;
    end
  endtask

  task automatic no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (o_valid) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  task automatic issue(input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    i_valid    = 1'b1;
    i_funct3   = f3;
    i_rs1_data = a;
    i_rs2_data = b;
    @(posedge clk);
    #1;
    i_valid    = 1'b0;
    i_funct3   = 3'($urandom);
    i_rs1_data = $urandom;
    i_rs2_data = $urandom;
  endtask

  task automatic run_op(input string tag,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int exp_lat);
    int lat;
    issue(f3, a, b);
    wait_valid(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, o_result, exp);
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    rst        = 1'b0;
    i_valid    = 1'b0;
    i_funct3   = 3'd0;
    i_rs1_data = '0;
    i_rs2_data = '0;
    i_flush    = 1'b0;
    i_ready    = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_busy",  {31'd0, o_busy},  32'd0);
    chk("rst_res",   o_result,         32'd0);
    rst = 1'b1;

    run_op("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    run_op("mul2",   3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 2);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run_op("mulhsu", 3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 2);
    run_op("mulhu",  3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run_op("mulhu2", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("div",    3'b100, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, DLAT);
    run_op("rem",    3'b110, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, DLAT);
    run_op("div_nb", 3'b100, 32'h0000_0014, 32'hFFFF_FFFD, 32'hFFFF_FFFA, DLAT);
    run_op("rem_nb", 3'b110, 32'h0000_0014, 32'hFFFF_FFFD, 32'h0000_0002, DLAT);
    run_op("divu",   3'b101, 32'hFFFF_FFEC, 32'h0000_0003, 32'h5555_554E, DLAT);
    run_op("remu",   3'b111, 32'hFFFF_FFEC, 32'h0000_0003, 32'h0000_0002, DLAT);
    run_op("divu_z", 3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 2);
    run_op("remu_z", 3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 2);
    run_op("div_z",  3'b100, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 2);
    run_op("rem_z",  3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 2);
    run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);

    // backpressure with a pending request
    i_ready = 1'b0;
    issue(3'b000, 32'd3, 32'd4);
    i_valid    = 1'b1;
    i_funct3   = 3'b000;
    i_rs1_data = 32'd5;
    i_rs2_data = 32'd6;
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_res",   o_result,         32'd12);
      chk("bp_ready", {31'd0, o_ready}, 32'd0);
    end
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_exit_valid", {31'd0, o_valid}, 32'd0);
    chk("bp_exit_ready", {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("bp_next_busy", {31'd0, o_busy}, 32'd1);
    i_valid = 1'b0;
    wait_valid(lat);
    chk("bp_next_lat", 32'(lat), 32'd2);
    chk("bp_next_res", o_result, 32'd30);
    @(posedge clk);
    #1;

    // flush at divide cycle 10
    issue(3'b100, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    chk("fl_div_busy", {31'd0, o_busy}, 32'd0);
    no_valid("fl_div_novalid", 40);

    // flush with a simultaneous request
    @(negedge clk);
    i_valid    = 1'b1;
    i_flush    = 1'b1;
    i_funct3   = 3'b000;
    i_rs1_data = 32'd2;
    i_rs2_data = 32'd2;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    chk("fl_req_busy", {31'd0, o_busy}, 32'd0);
    no_valid("fl_req_novalid", 5);

    // flush wins over i_ready in DONE
    i_ready = 1'b0;
    issue(3'b000, 32'd9, 32'd9);
    wait_valid(lat);
    chk("fl_done_lat", 32'(lat), 32'd2);
    @(negedge clk);
    i_flush = 1'b1;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    chk("fl_done_valid", {31'd0, o_valid}, 32'd0);
    chk("fl_done_ready", {31'd0, o_ready}, 32'd1);

    // reset in the middle of a divide
    issue(3'b101, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy",  {31'd0, o_busy},  32'd0);
    chk("rst_mid_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_mid_res",   o_result,         32'd0);
    @(negedge clk);
    rst = 1'b1;
    no_valid("rst_mid_novalid", 40);

    run_op("post_rst", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32im_mdu.md
RV32IM_MDU -- requirements
Module: rv32im_mdu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width; legal values are even and at least 8.
REQ-002 Parameter DIV_BITS, default 1, SHALL set the quotient bits resolved per divide cycle; legal values are 1 or 2, and WIDTH SHALL be divisible by DIV_BITS.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: one clock domain, asynchronous and active-low.
REQ-005 i_valid  input  1  SHALL indicate that a request is present.
REQ-006 o_ready  output  1  SHALL indicate that a request is accepted this cycle.
REQ-007 i_funct3  input  3  SHALL carry the M-extension funct3 opcode: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU = 000 through 111.
REQ-008 i_rs1_data, i_rs2_data  input  WIDTH  SHALL carry the operands a and b.
REQ-009 i_flush  input  1  SHALL abort any operation in progress.
REQ-010 o_valid  output  1  SHALL indicate that the result is presented.
REQ-011 i_ready  input  1  SHALL indicate that the consumer takes the result this cycle.
REQ-012 o_result  output  WIDTH  SHALL carry the result.
REQ-013 o_busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, MUL, DIV, FIX and DONE.
REQ-015 o_ready SHALL equal (state==IDLE); a request is accepted on a rising edge where i_valid and o_ready are both high, and the opcode and operands SHALL be captured at that edge, so later input changes are ignored.
REQ-016 On accepting a MUL-type request, IDLE SHALL go to MUL.
REQ-017 MUL SHALL register the full 2*WIDTH product, using signed/unsigned extension per funct3, and go to DONE, so o_valid rises 2 cycles after acceptance.
REQ-018 MUL SHALL return the low WIDTH bits of the product; MULH, MULHSU and MULHU SHALL return the high WIDTH bits.
REQ-019 On accepting a divide-type request with a nonzero divisor and no overflow, IDLE SHALL go to DIV.
REQ-020 DIV SHALL run a restoring divide on operand magnitudes for exactly WIDTH/DIV_BITS cycles, counted by a counter of width clog2(WIDTH/DIV_BITS)+1, then go to FIX.
REQ-021 FIX SHALL apply signs (quotient negative iff the operand signs differ; remainder takes the dividend's sign) and go to DONE, giving a divide latency of WIDTH/DIV_BITS+2 cycles.
REQ-022 Division by zero SHALL go IDLE to FIX to DONE (latency 2), returning quotient = all-ones and remainder = a, for both signed and unsigned opcodes.
REQ-023 Signed overflow (a = most-negative value, b = -1, DIV or REM) SHALL go IDLE to FIX to DONE, returning quotient = a and remainder = 0.
REQ-024 In DONE, o_valid SHALL be high and o_result SHALL hold stable until i_ready is sampled high, after which the state SHALL return to IDLE.
REQ-025 o_valid SHALL be high only in DONE.
REQ-026 There SHALL be no back-to-back acceptance in the DONE-exit cycle: the next request is accepted no earlier than the cycle after the return to IDLE.
REQ-027 i_flush high at a rising edge SHALL force IDLE from any state, discard the result and never produce o_valid for the aborted operation.
REQ-028 i_flush SHALL take priority over a simultaneous i_valid acceptance, so that request is dropped, and over a simultaneous i_ready in DONE.
REQ-029 The arithmetic SHALL wrap modulo 2^WIDTH, with no exceptions or flags.

Reset
REQ-030 While rst is low, state SHALL be IDLE, o_valid = 0, o_busy = 0, o_ready = 1, o_result = 0, and the counter and datapath registers SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL abort that operation with no o_valid after release.
REQ-032 Release of rst SHALL be synchronised by the instantiating level; this block assumes release is synchronous to clk.

Structure
REQ-033 The funct3 encodings and the FSM state enum SHALL live in the shared package rv32im_pkg, next to the existing ALU opcode definitions.
REQ-034 The divider iteration datapath SHALL be the sub-module rv32im_div_step, parametrised by WIDTH and DIV_BITS, taking the partial remainder, quotient and divisor and returning their next values; the multiplier SHALL be inline.

Verification
REQ-035 MUL: a=0x0000_0007, b=0xFFFF_FFFD, i_ready=1 -> o_valid exactly 2 cycles after acceptance, o_result=0xFFFF_FFEB.
REQ-036 MULH/MULHSU/MULHU: a=b=0x8000_0000 -> results 0x4000_0000, 0xC000_0000, 0x4000_0000.
REQ-037 DIV/REM: a=-20 (0xFFFF_FFEC), b=3, DIV_BITS=1 -> DIV=0xFFFF_FFFA after 34 cycles and REM=0xFFFF_FFFE; the DIV_BITS=2 build gives the same values after 18 cycles.
REQ-038 Corner cases: DIVU 5/0 -> 0xFFFF_FFFF; REMU 5/0 -> 5; DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000; REM of the same operands -> 0; each with latency 2.
REQ-039 Backpressure: i_ready held low for 5 cycles in DONE -> o_valid and o_result stable and o_ready low throughout; the next request is accepted only after i_ready.
REQ-040 Flush and reset: i_flush pulsed at DIV cycle 10 -> IDLE next cycle, no o_valid; i_flush together with i_valid in IDLE -> request dropped; rst low mid-DIV -> IDLE, no o_valid after release.
